// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: FUNC3 encodings and the mul/div unit state enum.
package rv32m_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_div_core.sv
// Iterative 32-step restoring divider on operand magnitudes, with sign fix-up
// of quotient and remainder applied on the outputs.
module ex_div_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [4:0]  cnt_q,  cnt_d;
    logic [31:0] rem_q,  rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic [32:0] shifted;
    logic [32:0] diff;

    // Load magnitudes on start, otherwise perform one shift/trial-subtract step.
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        shifted = {rem_q, quot_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        if (load) begin
            quot_d = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
            dvsr_d = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
            rem_d  = 32'd0;
            cnt_d  = 5'd31;
            negq_d = is_signed & (dividend[31] ^ divisor[31]);
            negr_d = is_signed & dividend[31];
        end else if (step) begin
            // A non-negative difference is always below the divisor, so 32 bits hold it.
            if (!diff[32]) begin
                rem_d  = diff[31:0];
                quot_d = {quot_q[30:0], 1'b1};
            end else begin
                rem_d  = shifted[31:0];
                quot_d = {quot_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 5'd1;
        end
    end

    // Divider state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 5'd0;
            rem_q  <= 32'd0;
            quot_q <= 32'd0;
            dvsr_q <= 32'd0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign last      = (cnt_q == 5'd0);
    assign quotient  = negq_q ? (32'd0 - quot_q) : quot_q;
    assign remainder = negr_q ? (32'd0 - rem_q)  : rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M EX-stage multiply/divide unit: single-cycle multiply, iterative divide,
// combinational STALL toward the pipeline and a one-cycle DONE pulse.
module ex_muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    md_state_e       state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;

    logic signed [63:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]    mul_res;
    logic               div_by_zero, div_ovf;
    logic [XLEN-1:0]    special_res;
    logic               div_load, div_step, div_last;
    logic [XLEN-1:0]    div_quot, div_rem;

    // Multiplier operands are the 33-bit signed views (sign bit forced to 0 for
    // unsigned operands), sign-extended so the low 64 product bits are exact.
    always_comb begin
        mul_a   = {{32{(FUNC3 != M_MULHU) & OPERAND_A[31]}}, OPERAND_A};
        mul_b   = {{32{(FUNC3 == M_MULH)  & OPERAND_B[31]}}, OPERAND_B};
        prod    = mul_a * mul_b;
        mul_res = (FUNC3 == M_MUL) ? prod[31:0] : prod[63:32];
    end

    // Divide corner cases that bypass the iterative divider.
    always_comb begin
        div_by_zero = (OPERAND_B == '0);
        div_ovf     = ~FUNC3[0] & (OPERAND_A == 32'h8000_0000) & (OPERAND_B == 32'hFFFF_FFFF);
        if (div_by_zero)
            special_res = FUNC3[1] ? OPERAND_A : 32'hFFFF_FFFF;
        else
            special_res = FUNC3[1] ? 32'd0 : 32'h8000_0000;
    end

    ex_div_core u_div (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (div_load),
        .step      (div_step),
        .is_signed (~FUNC3[0]),
        .dividend  (OPERAND_A),
        .divisor   (OPERAND_B),
        .last      (div_last),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Next-state and result selection; FLUSH overrides everything and keeps RESULT.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        div_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    is_rem_d = FUNC3[1];
                    if (!FUNC3[2]) begin
                        result_d = mul_res;
                        state_d  = ST_DONE;
                    end else if (div_by_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        div_load = 1'b1;
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX: begin
                result_d = is_rem_q ? div_rem : div_quot;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (FLUSH) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            div_load = 1'b0;
        end
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign div_step = (state_q == ST_DIV);
    assign STALL    = RST_N & ~FLUSH & (((state_q == ST_IDLE) & START) |
                                        (state_q == ST_DIV) | (state_q == ST_FIX));
    assign DONE     = (state_q == ST_DONE);
    assign RESULT   = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a queue-based result scoreboard.
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        FLUSH;
    logic [2:0]  FUNC3;
    logic [31:0] OPERAND_A;
    logic [31:0] OPERAND_B;
    logic        STALL;
    logic        DONE;
    logic [31:0] RESULT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .FLUSH     (FLUSH),
        .FUNC3     (FUNC3),
        .OPERAND_A (OPERAND_A),
        .OPERAND_B (OPERAND_B),
        .STALL     (STALL),
        .DONE      (DONE),
        .RESULT    (RESULT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an M instruction into EX and record its expected result.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        @(negedge CLK);
        FUNC3     = f;
        OPERAND_A = a;
        OPERAND_B = b;
        START     = 1'b1;
        exp_q.push_back(exp);
    endtask

    // Hold START until DONE, scrambling operands while stalled, then score the result.
    task automatic finish_op(input string tag, input int exp_lat, input int exp_stall);
        int lat    = 0;
        int stalls = 0;
        bit got    = 0;
        logic [31:0] exp;
        #1;
        if (STALL === 1'b1) stalls++;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (DONE === 1'b1) begin
                got = 1;
            end else begin
                if (STALL === 1'b1) stalls++;
                OPERAND_A = $urandom;
                OPERAND_B = $urandom;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed no DONE expected DONE within 60 cycles", tag);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
            chk({tag, "_stall_in_done"}, {31'd0, STALL}, 32'd0);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                chk({tag, "_result"}, RESULT, exp);
                last_res = exp;
            end
        end
        @(negedge CLK);
        START = 1'b0;
        chk({tag, "_done_one_cycle"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int done_seen;
        RST_N     = 1'b0;
        START     = 1'b0;
        FLUSH     = 1'b0;
        FUNC3     = 3'b000;
        OPERAND_A = 32'd0;
        OPERAND_B = 32'd0;
        repeat (3) @(negedge CLK);
        chk("rst_stall", {31'd0, STALL}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        START = 1'b1;
        #1;
        chk("rst_stall_with_start", {31'd0, STALL}, 32'd0);
        START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        // Multiplies: one cycle each
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        finish_op("mul", 1, 1);
        start_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        finish_op("mulh", 1, 1);
        start_op(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        finish_op("mulhu", 1, 1);
        start_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("mulhsu", 1, 1);

        // Normal divides: 34 cycles each
        start_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        finish_op("div", 34, 34);
        start_op(3'b110, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op("rem", 34, 34);
        start_op(3'b111, 32'd100, 32'd7, 32'd2);
        finish_op("remu", 34, 34);

        // Flush in DIV cycle 10
        @(negedge CLK);
        FUNC3     = 3'b100;
        OPERAND_A = 32'd1000;
        OPERAND_B = 32'd3;
        START     = 1'b1;
        repeat (10) @(negedge CLK);
        FLUSH = 1'b1;
        #1;
        chk("flush_stall_same_cycle", {31'd0, STALL}, 32'd0);
        @(negedge CLK);
        FLUSH = 1'b0;
        START = 1'b0;
        chk("flush_done", {31'd0, DONE}, 32'd0);
        chk("flush_stall", {31'd0, STALL}, 32'd0);
        chk("flush_result_kept", RESULT, last_res);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_seen++;
        end
        chk("flush_no_done_pulse", 32'(done_seen), 32'd0);
        start_op(3'b101, 32'd9, 32'd2, 32'd4);
        finish_op("divu_after_flush", 34, 34);

        // Special cases: one cycle each
        start_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        finish_op("divu_by_zero", 1, 1);
        start_op(3'b110, 32'd5, 32'd0, 32'd5);
        finish_op("rem_by_zero", 1, 1);
        start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        finish_op("div_ovf", 1, 1);
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        finish_op("rem_ovf", 1, 1);

        // Reset mid-divide, then MUL 3x4 with START held through release
        @(negedge CLK);
        FUNC3     = 3'b101;
        OPERAND_A = 32'd1000;
        OPERAND_B = 32'd7;
        START     = 1'b1;
        repeat (5) @(negedge CLK);
        RST_N     = 1'b0;
        FUNC3     = 3'b000;
        OPERAND_A = 32'd3;
        OPERAND_B = 32'd4;
        #1;
        chk("midrst_stall", {31'd0, STALL}, 32'd0);
        @(negedge CLK);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        chk("midrst_result", RESULT, 32'd0);
        RST_N = 1'b1;
        exp_q.push_back(32'd12);
        finish_op("mul_after_rst", 1, 1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
